// File: rtl/mac_arbiter.sv
// Round-robin arbiter that shares one external MAC among NREQ requesters.
// Each granted job streams req_len operand pairs into the MAC and returns one accumulated result.
module mac_arbiter #(
  parameter int NREQ  = 4,
  parameter int LEN_W = 8,
  parameter int TMO   = 15,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW   = (TMO > 0) ? $clog2(TMO + 1) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       op_valid,
  input  logic [NREQ*8-1:0]     op_a,
  input  logic [NREQ*8-1:0]     op_b,
  output logic [NREQ-1:0]       op_ready,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [31:0]           res_data,
  output logic                  res_err,
  output logic                  mac_valid,
  output logic                  mac_clr,
  output logic [7:0]            mac_a,
  output logic [7:0]            mac_b,
  input  logic                  mac_done,
  input  logic [31:0]           mac_y
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, ISSUE, WAIT, RESULT} state_t;

  state_t            state_q;
  logic [IDW-1:0]    rr_q, gnt_q, gnt_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [TW-1:0]     tmo_q;
  logic [NREQ-1:0]   op_ready_q;
  logic              res_valid_q, res_err_q, zero_q;
  logic              mac_valid_q, mac_clr_q;
  logic [7:0]        mac_a_q, mac_b_q;
  logic              found;

  // First requesting index at or after the rr pointer, wrapping around.
  always_comb begin
    gnt_d = rr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(rr_q) + k) % NREQ]) begin
        gnt_d = IDW'((int'(rr_q) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      op_ready_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      zero_q      <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q     <= gnt_d;
            cnt_q     <= req_len[int'(gnt_d)*LEN_W +: LEN_W];
            mac_clr_q <= 1'b1;
            state_q   <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clr_q <= 1'b0;
          res_err_q <= 1'b0;
          zero_q    <= (cnt_q == '0);
          if (cnt_q != '0) begin
            op_ready_q <= NREQ'(1) << gnt_q;
            state_q    <= FEED;
          end else begin
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        FEED: begin
          if (op_valid[gnt_q]) begin
            mac_a_q     <= op_a[int'(gnt_q)*8 +: 8];
            mac_b_q     <= op_b[int'(gnt_q)*8 +: 8];
            op_ready_q  <= '0;
            mac_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mac_valid_q <= 1'b0;
          tmo_q       <= TW'(TMO);
          state_q     <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the last timeout cycle still counts as success.
          if (mac_done) begin
            tmo_q <= '0;
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              res_valid_q <= 1'b1;
              state_q     <= RESULT;
            end else begin
              op_ready_q <= NREQ'(1) << gnt_q;
              state_q    <= FEED;
            end
          end else if (tmo_q == TW'(1) || tmo_q == '0) begin
            tmo_q       <= '0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        RESULT: begin
          res_valid_q <= 1'b0;
          res_err_q   <= 1'b0;
          zero_q      <= 1'b0;
          rr_q        <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // res_data follows mac_y during the RESULT cycle itself.
  assign res_data  = (res_valid_q && !zero_q) ? mac_y : '0;
  assign res_id    = res_valid_q ? gnt_q : '0;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign op_ready  = op_ready_q;
  assign mac_valid = mac_valid_q;
  assign mac_clr   = mac_clr_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Bench for mac_arbiter: behavioural MAC, per-requester operand feeders, vector table,
// directed corner sequences and randomized jobs checked against a dot-product model.
module tb_mac_arbiter;
  localparam int NREQ = 4, LEN_W = 8, TMO = 15, IDW = 2, MAXP = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       op_valid;
  logic [NREQ*8-1:0]     op_a, op_b;
  logic [NREQ-1:0]       op_ready;
  logic                  res_valid, res_err, mac_valid, mac_clr;
  logic [IDW-1:0]        res_id;
  logic [31:0]           res_data;
  logic [7:0]            mac_a, mac_b;
  logic                  mac_done;
  logic [31:0]           mac_y;

  mac_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_err(res_err),
    .mac_valid(mac_valid), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
    .mac_done(mac_done), .mac_y(mac_y)
  );

  always #5 clk = ~clk;

  // Operand storage per requester; fidx walks through the pairs as they are accepted.
  logic signed [7:0] pa [NREQ][MAXP];
  logic signed [7:0] pb [NREQ][MAXP];
  int plen [NREQ];
  int fidx [NREQ];
  bit stall_en = 1'b0;
  bit stall = 1'b0;
  int mac_lat = 4;
  bit mac_never = 1'b0;

  always_comb begin
    op_a = '0; op_b = '0; op_valid = '0; req_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*LEN_W +: LEN_W] = LEN_W'(plen[i]);
      if (fidx[i] < plen[i] && fidx[i] < MAXP) begin
        op_valid[i] = !stall;
        op_a[i*8 +: 8] = pa[i][fidx[i]];
        op_b[i*8 +: 8] = pb[i][fidx[i]];
      end
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) fidx[i] <= 0;
    end else if (mac_clr) begin
      for (int i = 0; i < NREQ; i++) fidx[i] <= 0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (op_ready[i] && op_valid[i]) fidx[i] <= fidx[i] + 1;
    end
  end

  always @(negedge clk) stall <= stall_en ? 1'($urandom_range(0, 1)) : 1'b0;

  // Behavioural MAC: result and done pulse appear mac_lat cycles after mac_valid.
  logic signed [7:0]  ma, mb;
  logic signed [31:0] acc;
  int mcnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0; mac_done <= 1'b0; mac_y <= '0; acc <= '0; ma <= '0; mb <= '0;
    end else begin
      mac_done <= 1'b0;
      if (mac_clr) begin acc <= '0; mac_y <= '0; end
      if (mac_valid && !mac_never) begin
        mcnt <= mac_lat; ma <= mac_a; mb <= mac_b;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          mac_done <= 1'b1;
          acc   <= acc + ma * mb;
          mac_y <= acc + ma * mb;
        end
      end
    end
  end

  int cyc = 0, n_clr = 0, n_mv = 0, last_mv = 0, onehot_viol = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mac_clr) n_clr <= n_clr + 1;
    if (mac_valid) begin n_mv <= n_mv + 1; last_mv <= cyc; end
  end
  always @(negedge clk) if (!reset && $countones(op_ready) > 1) onehot_viol <= onehot_viol + 1;

  int checks = 0, errors = 0;
  int rr_m = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int pick_m(input int rr, input logic [3:0] r);
    for (int k = 0; k < NREQ; k++) if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic int dot(input int g);
    int s = 0;
    for (int k = 0; k < plen[g]; k++) s += int'(pa[g][k]) * int'(pb[g][k]);
    return s;
  endfunction

  task automatic wait_res(output int id, output int data, output int err, output int rcyc);
    bit got = 1'b0;
    id = -1; data = 0; err = -1; rcyc = 0;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      if (res_valid) begin
        id = int'(res_id); data = $signed(res_data); err = int'(res_err); rcyc = cyc; got = 1'b1;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL wait_res got no res_valid expected one within 600 cycles");
    end
  endtask

  task automatic do_job(input logic [3:0] r, output int id, output int data, output int err,
                        output int rcyc, output int dclr, output int dmv);
    int c0, v0;
    c0 = n_clr; v0 = n_mv;
    req = r;
    wait_res(id, data, err, rcyc);
    dclr = n_clr - c0;
    dmv  = n_mv - v0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    rr_m = 0;
  endtask

  typedef struct {
    logic [3:0] r; int len; int a0; int b0; int a1; int b1; int eid; int edata;
  } vec_t;
  vec_t tbl [8];

  int id, data, err, rcyc, dclr, dmv, g, exp_d, v0;
  logic [3:0] r;
  int rr_order [5];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Table assumes rr starts at 0 and advances per the grant sequence.
    tbl[0] = '{4'b0001, 2,    3,    4, -2,   5, 0,      2};
    tbl[1] = '{4'b0100, 0,    0,    0,  0,   0, 2,      0};
    tbl[2] = '{4'b0001, 1, -128, -128,  0,   0, 0,  16384};
    tbl[3] = '{4'b0001, 1,  127, -128,  0,   0, 0, -16256};
    tbl[4] = '{4'b1001, 1,    5,   -7,  0,   0, 3,    -35};
    tbl[5] = '{4'b1001, 2,    1,    1,  2,   3, 0,      7};
    tbl[6] = '{4'b0110, 2,   -1,   -1, 10, -10, 1,    -99};
    tbl[7] = '{4'b0110, 1,    6,    6,  0,   0, 2,     36};
    rr_order = '{0, 1, 2, 3, 0};

    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 0;
      for (int k = 0; k < MAXP; k++) begin pa[i][k] = '0; pb[i][k] = '0; end
    end
    req = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_outputs", longint'({op_ready, res_valid, res_id, res_data, res_err,
                                   mac_valid, mac_clr, mac_a, mac_b}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rr_m = 0;

    // Round robin with all requests held high.
    for (int i = 0; i < NREQ; i++) begin
      plen[i] = 1;
      pa[i][0] = 8'(i + 2); pb[i][0] = 8'(-3 * (i + 1));
    end
    for (int j = 0; j < 5; j++) begin
      do_job(4'b1111, id, data, err, rcyc, dclr, dmv);
      chk($sformatf("rr_grant_%0d", j), id, rr_order[j]);
      chk($sformatf("rr_data_%0d", j), data, (rr_order[j] + 2) * (-3 * (rr_order[j] + 1)));
    end

    pulse_reset();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        plen[i] = tbl[t].len;
        pa[i][0] = 8'(tbl[t].a0); pb[i][0] = 8'(tbl[t].b0);
        pa[i][1] = 8'(tbl[t].a1); pb[i][1] = 8'(tbl[t].b1);
      end
      g = pick_m(rr_m, tbl[t].r);
      do_job(tbl[t].r, id, data, err, rcyc, dclr, dmv);
      chk($sformatf("tbl%0d_id", t), id, tbl[t].eid);
      chk($sformatf("tbl%0d_data", t), data, tbl[t].edata);
      chk($sformatf("tbl%0d_err", t), err, 0);
      chk($sformatf("tbl%0d_clr_pulses", t), dclr, 1);
      chk($sformatf("tbl%0d_valid_pulses", t), dmv, tbl[t].len);
      rr_m = (g + 1) % NREQ;
    end

    // MAC never completes: timeout aborts, then the next job runs normally.
    mac_never = 1'b1;
    plen[1] = 2; pa[1][0] = 8'(9); pb[1][0] = 8'(9);
    g = pick_m(rr_m, 4'b0010);
    do_job(4'b0010, id, data, err, rcyc, dclr, dmv);
    chk("tmo_id", id, 1);
    chk("tmo_err", err, 1);
    chk("tmo_latency", rcyc - last_mv, TMO + 1);
    chk("tmo_valid_pulses", dmv, 1);
    rr_m = (g + 1) % NREQ;
    mac_never = 1'b0;
    plen[1] = 1; pa[1][0] = 8'(-11); pb[1][0] = 8'(4);
    do_job(4'b0010, id, data, err, rcyc, dclr, dmv);
    chk("post_tmo_id", id, 1);
    chk("post_tmo_err", err, 0);
    chk("post_tmo_data", data, -44);

    // Reset in the middle of WAIT.
    mac_lat = 10;
    plen[0] = 1; pa[0][0] = 8'(7); pb[0][0] = 8'(9);
    v0 = n_mv;
    req = 4'b0001;
    for (int c = 0; c < 50 && n_mv == v0; c++) @(negedge clk);
    chk("midjob_issue_seen", n_mv - v0, 1);
    @(negedge clk);
    chk("midjob_mac_a_held", longint'(mac_a), 7);
    #2 reset = 1'b1;
    #1;
    chk("midjob_reset_outputs", longint'({op_ready, res_valid, res_id, res_data, res_err,
                                          mac_valid, mac_clr, mac_a, mac_b}), 0);
    @(negedge clk);
    reset = 1'b0;
    rr_m = 0;
    mac_lat = 4;
    plen[0] = 1; plen[1] = 1;
    pa[0][0] = 8'(-5); pb[0][0] = 8'(6);
    pa[1][0] = 8'(3);  pb[1][0] = 8'(3);
    do_job(4'b0011, id, data, err, rcyc, dclr, dmv);
    chk("after_reset_id", id, 0);
    chk("after_reset_data", data, -30);
    rr_m = 1;

    // Randomized jobs with operand stalls and varying MAC latency.
    stall_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        plen[i] = $urandom_range(0, 4);
        for (int k = 0; k < MAXP; k++) begin
          pa[i][k] = 8'($urandom_range(0, 255));
          pb[i][k] = 8'($urandom_range(0, 255));
        end
      end
      r = 4'($urandom_range(1, 15));
      mac_lat = $urandom_range(1, 6);
      g = pick_m(rr_m, r);
      exp_d = dot(g);
      do_job(r, id, data, err, rcyc, dclr, dmv);
      chk($sformatf("rnd%0d_id", j), id, g);
      chk($sformatf("rnd%0d_data", j), data, exp_d);
      chk($sformatf("rnd%0d_err", j), err, 0);
      chk($sformatf("rnd%0d_valid_pulses", j), dmv, plen[g]);
      rr_m = (g + 1) % NREQ;
    end
    stall_en = 1'b0;

    chk("op_ready_onehot_violations", onehot_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one MAC datapath.
REQ-002 Parameter LEN_W, default 8, width of the per-job pair count.
REQ-003 Parameter TMO, default 15, cycles allowed between mac_valid and mac_done.
REQ-004 clk  input  1  clock, all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 req  input  NREQ  per-requester job request, level.
REQ-007 req_len  input  NREQ*LEN_W  per-requester pair count, slice i for requester i.
REQ-008 op_valid  input  NREQ  per-requester operand pair valid.
REQ-009 op_a, op_b  input  NREQ*8 each  per-requester signed 8-bit operands.
REQ-010 op_ready  output  NREQ  operand pair accepted, one-hot or zero.
REQ-011 res_valid  output  1  one-cycle pulse, job result present.
REQ-012 res_id  output  $clog2(NREQ)  requester owning res_data.
REQ-013 res_data  output  32  signed accumulated dot product.
REQ-014 res_err  output  1  job aborted on MAC timeout, qualified by res_valid.
REQ-015 mac_valid, mac_clr  output  1 each  MAC start pulse; MAC accumulator clear pulse.
REQ-016 mac_a, mac_b  output  8 each  signed operands to MAC.
REQ-017 mac_done, mac_y  input  1, 32  MAC completion pulse; MAC accumulator value.

Function
REQ-018 FSM states IDLE, CLEAR, FEED, ISSUE, WAIT, RESULT; exactly one active.
REQ-019 IDLE: when req nonzero, grant the first set bit at or after rr pointer (wrapping); latch gnt id and req_len[gnt] into cnt; go CLEAR.
REQ-020 req, req_len sampled only in IDLE; changes during a job ignored.
REQ-021 CLEAR: mac_clr=1 for exactly one cycle; next FEED if cnt!=0, else RESULT with res_data=0.
REQ-022 FEED: op_ready[gnt]=1, all other op_ready bits 0; on op_valid[gnt] capture op_a/op_b slices into mac_a/mac_b registers, go ISSUE.
REQ-023 op_valid of non-granted requesters ignored; op_ready low in all states except FEED.
REQ-024 ISSUE: mac_valid=1 for exactly one cycle; load timeout counter with TMO; go WAIT.
REQ-025 mac_a, mac_b held stable from capture until mac_done or timeout.
REQ-026 WAIT: on mac_done decrement cnt; cnt reaching 0 -> RESULT, else FEED.
REQ-027 WAIT: timeout counter decrements each cycle without mac_done; reaching 0 -> RESULT with res_err=1.
REQ-028 mac_done outside WAIT ignored.
REQ-029 RESULT: one cycle; res_valid=1, res_id=gnt, res_data=mac_y sampled this cycle (0 if len was 0), res_err per REQ-027; rr pointer <= gnt+1 mod NREQ; go IDLE.
REQ-030 Minimum job latency, IDLE grant to res_valid: 3 + per-pair (FEED handshake + ISSUE + MAC latency) cycles.
REQ-031 No job preemption; a granted requester keeps MAC until RESULT.
REQ-032 Round-robin fairness: with all req held high, grants cycle 0,1,...,NREQ-1,0.

Reset
REQ-033 reset asserted: state IDLE, rr pointer 0, cnt 0, timeout 0; all outputs 0 immediately, including mid-job.
REQ-034 First grant evaluated on the first rising edge after reset deasserts.

Verification
REQ-035 req=0001, len0=2, pairs (3,4),(-2,5), MAC model 4-cycle done -> one mac_clr, two mac_valid pulses, res_valid with res_id=0, res_data=2, res_err=0.
REQ-036 req=1111 held, len=1 each -> grant order 0,1,2,3,0; no overlapping op_ready bits.
REQ-037 req=0100, len2=0 -> mac_clr pulse, no mac_valid, res_id=2, res_data=0.
REQ-038 MAC model never asserts mac_done -> res_valid TMO+1 cycles after mac_valid with res_err=1; next job granted normally.
REQ-039 Operands (-128,-128), len=1 -> res_data=16384; (127,-128) -> res_data=-16256.
REQ-040 reset asserted during WAIT -> all outputs 0 same cycle; after release rr pointer 0, req=0011 grants requester 0 first.
